// File: rtl/mem_access_stage_if.sv
// Execute-side inputs, memory req/done port and writeback outputs of the memory stage.
// master = the stage itself; slave = the surrounding pipeline/memory environment.
interface mem_access_stage_if #(parameter int ADDR_W = 16);
    logic              ex_valid;
    logic [ADDR_W-1:0] ALU_out;
    logic [ADDR_W-1:0] data_2_out;
    logic              mem_read;
    logic              mem_write;
    logic              halt;
    logic              mem_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_wdata;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_rdata;
    logic              mem_done;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_data;
    logic              wb_is_load;
    logic              mem_err;
    logic              halted;

    modport master (
        input  ex_valid, ALU_out, data_2_out, mem_read, mem_write, halt, mem_rdata, mem_done,
        output mem_stall, mem_addr, mem_wdata, mem_rd_req, mem_wr_req,
               wb_valid, wb_data, wb_is_load, mem_err, halted
    );

    modport slave (
        output ex_valid, ALU_out, data_2_out, mem_read, mem_write, halt, mem_rdata, mem_done,
        input  mem_stall, mem_addr, mem_wdata, mem_rd_req, mem_wr_req,
               wb_valid, wb_data, wb_is_load, mem_err, halted
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: non-memory results registered (1 cycle); loads/stores use the req/done port with a MAX_WAIT timeout.
// Stalls upstream until the access completes; with MEM_ALIGN_CHECK_EN odd-address memory ops are rejected.
module mem_access_stage #(
    parameter int MAX_WAIT = 15,
    parameter int ADDR_W   = 16
) (
    input logic               clk,
    input logic               rst_n,
    mem_access_stage_if.master mas
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] wdata;
    } req_t;

    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

    state_t            state, state_nxt;
    req_t              req;
    logic [7:0]        cnt;
    logic              wb_valid, wb_is_load, mem_err, halted;
    logic [ADDR_W-1:0] wb_data;
    logic              stall;
    logic              mem_op, live, misalign, accept, reject, pass, timeout, finish;

    always_comb begin
        mem_op = mas.mem_read | mas.mem_write;
        live   = (state == IDLE) && mas.ex_valid && !halted;
`ifdef MEM_ALIGN_CHECK_EN
        misalign = mas.ALU_out[0];
`else
        misalign = 1'b0;
`endif
        // A halt op is treated as a plain pass-through even if memory flags are set.
        accept  = live && mem_op && !mas.halt && !misalign;
        reject  = live && mem_op && !mas.halt && misalign;
        pass    = live && (!mem_op || mas.halt);
        timeout = (state == ACCESS) && !mas.mem_done && (cnt == LAST);
        finish  = (state == ACCESS) && (mas.mem_done || timeout);
    end

    // Stall drops in the final ACCESS cycle so upstream advances together with completion.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ACCESS;
                    stall     = 1'b1;
                end
            end
            ACCESS: begin
                if (finish) state_nxt = IDLE;
                else        stall     = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req        <= '0;
            cnt        <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_is_load <= 1'b0;
            mem_err    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wb_valid <= 1'b0;
            if (accept) begin
                req.rd    <= mas.mem_read;
                req.addr  <= mas.ALU_out;
                req.wdata <= mas.data_2_out;
                cnt       <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 8'd1;
            end
            if (pass) begin
                wb_valid   <= 1'b1;
                wb_data    <= mas.ALU_out;
                wb_is_load <= 1'b0;
                if (mas.halt) halted <= 1'b1;
            end
            if (reject) begin
                wb_valid   <= 1'b1;
                wb_data    <= '0;
                wb_is_load <= 1'b0;
                mem_err    <= 1'b1;
            end
            if (finish) begin
                wb_valid <= 1'b1;
                if (mas.mem_done) begin
                    wb_data    <= req.rd ? mas.mem_rdata : req.addr;
                    wb_is_load <= req.rd;
                end else begin
                    wb_data    <= '0;
                    wb_is_load <= 1'b0;
                    mem_err    <= 1'b1;
                end
            end
        end
    end

    assign mas.mem_stall  = stall;
    assign mas.mem_addr   = req.addr;
    assign mas.mem_wdata  = req.wdata;
    assign mas.mem_rd_req = (state == ACCESS) && req.rd;
    assign mas.mem_wr_req = (state == ACCESS) && !req.rd;
    assign mas.wb_valid   = wb_valid;
    assign mas.wb_data    = wb_data;
    assign mas.wb_is_load = wb_is_load;
    assign mas.mem_err    = mem_err;
    assign mas.halted     = halted;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (MAX_WAIT=4); expected writeback results are queued at issue
// and a negedge monitor pops and compares each wb_valid pulse.
module tb_mem_access_stage;
    localparam int MAXW = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        is_load;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_wb    = 0;
    wb_t  exp_q[$];

    mem_access_stage_if #(.ADDR_W(16)) bus ();

    mem_access_stage #(.MAX_WAIT(MAXW), .ADDR_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mas  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic ld);
        wb_t e;
        e.data    = d;
        e.is_load = ld;
        exp_q.push_back(e);
    endtask

    task automatic idle_in();
        bus.ex_valid   = 1'b0;
        bus.ALU_out    = '0;
        bus.data_2_out = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.halt       = 1'b0;
        bus.mem_done   = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one memory op and hold it until completion; done_at=0 means memory never answers.
    task automatic mem_op(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wd, input int done_at, input logic [15:0] rdata);
        int limit;
        limit = (done_at > 0) ? done_at : MAXW;
        if (done_at > 0) push(rd ? rdata : addr, rd);
        else             push(16'h0000, 1'b0);
        bus.ex_valid   = 1'b1;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.ALU_out    = addr;
        bus.data_2_out = wd;
        @(negedge clk);
        chk("accept_stall", bus.mem_stall, 1);
        chk("accept_noreq", {bus.mem_rd_req, bus.mem_wr_req}, 0);
        next_cycle();
        for (int k = 1; k <= limit; k++) begin
            bus.mem_done  = (k == done_at);
            bus.mem_rdata = rdata;
            @(negedge clk);
            chk("access_req", {bus.mem_rd_req, bus.mem_wr_req}, rd ? 2'b10 : 2'b01);
            chk("access_addr", bus.mem_addr, addr);
            chk("access_wdata", bus.mem_wdata, wd);
            chk("access_stall", bus.mem_stall, (k == limit) ? 0 : 1);
            next_cycle();
        end
        idle_in();
        chk("req_dropped", {bus.mem_rd_req, bus.mem_wr_req}, 0);
    endtask

    always @(negedge clk) begin
        if (bus.wb_valid) begin
            n_wb++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: got data %h, expected no result (t=%0t)", bus.wb_data, $time);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_data", bus.wb_data, e.data);
                chk("wb_is_load", bus.wb_is_load, e.is_load);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.mem_stall, bus.mem_rd_req, bus.mem_wr_req, bus.wb_valid,
                              bus.wb_is_load, bus.mem_err, bus.halted}, 0);
        chk("reset_buses", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("reset_wb_data", bus.wb_data, 0);
        rst_n = 1'b1;
        next_cycle();

        // ALU pass-through
        bus.ex_valid = 1'b1;
        bus.ALU_out  = 16'h1234;
        push(16'h1234, 1'b0);
        @(negedge clk);
        chk("pass_stall", bus.mem_stall, 0);
        next_cycle();
        idle_in();
        @(negedge clk);
        chk("pass_stall_after", bus.mem_stall, 0);
        next_cycle();

        // Load, store, back-to-back load
        mem_op(1'b1, 1'b0, 16'h0040, 16'h0000, 3, 16'hBEEF);
        next_cycle();
        mem_op(1'b0, 1'b1, 16'h0100, 16'hA5A5, 1, 16'h0000);
        mem_op(1'b1, 1'b0, 16'h0200, 16'h0000, 2, 16'h1357);
        next_cycle();

        // Completion on the timeout cycle wins, then a real timeout
        mem_op(1'b1, 1'b0, 16'h0300, 16'h0000, MAXW, 16'h7777);
        chk("done_on_last_no_err", bus.mem_err, 0);
        mem_op(1'b1, 1'b0, 16'h0310, 16'h0000, 0, 16'h0000);
        chk("timeout_err", bus.mem_err, 1);
        mem_op(1'b1, 1'b0, 16'h0010, 16'h0000, 2, 16'h2222);
        chk("err_sticky", bus.mem_err, 1);

        // mem_done while idle is ignored
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk("idle_done_noreq", {bus.mem_rd_req, bus.mem_wr_req, bus.mem_stall}, 0);
        next_cycle();
        idle_in();
        next_cycle();

        // Read wins over write
        mem_op(1'b1, 1'b1, 16'h0400, 16'hFFFF, 2, 16'h4444);
        next_cycle();

        // Reset in the middle of an access
        bus.ex_valid = 1'b1;
        bus.mem_read = 1'b1;
        bus.ALU_out  = 16'h0500;
        next_cycle();
        @(negedge clk);
        chk("pre_reset_req", bus.mem_rd_req, 1);
        #2;
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("async_reset_req", {bus.mem_rd_req, bus.mem_wr_req, bus.mem_stall, bus.mem_err}, 0);
        chk("async_reset_addr", bus.mem_addr, 0);
        next_cycle();
        rst_n = 1'b1;
        repeat (2) next_cycle();

        // Odd address
`ifdef MEM_ALIGN_CHECK_EN
        bus.ex_valid = 1'b1;
        bus.mem_read = 1'b1;
        bus.ALU_out  = 16'h0041;
        push(16'h0000, 1'b0);
        @(negedge clk);
        chk("align_stall", bus.mem_stall, 0);
        next_cycle();
        idle_in();
        chk("align_noreq", {bus.mem_rd_req, bus.mem_wr_req}, 0);
        chk("align_err", bus.mem_err, 1);
`else
        mem_op(1'b1, 1'b0, 16'h0041, 16'h0000, 1, 16'hC0DE);
        chk("odd_no_err", bus.mem_err, 0);
`endif
        next_cycle();

        // Halt, then everything is ignored
        bus.ex_valid = 1'b1;
        bus.halt     = 1'b1;
        bus.ALU_out  = 16'h0777;
        push(16'h0777, 1'b0);
        @(negedge clk);
        chk("halt_stall", bus.mem_stall, 0);
        next_cycle();
        chk("halted_set", bus.halted, 1);
        bus.halt     = 1'b0;
        bus.mem_read = 1'b1;
        bus.ALU_out  = 16'h0888;
        @(negedge clk);
        chk("halted_ignore", {bus.mem_stall, bus.mem_rd_req, bus.mem_wr_req}, 0);
        next_cycle();
        bus.mem_read = 1'b0;
        bus.ALU_out  = 16'h0999;
        repeat (2) next_cycle();
        chk("halted_noreq", {bus.mem_rd_req, bus.mem_wr_req}, 0);
        chk("halted_sticky", bus.halted, 1);
        idle_in();
        repeat (2) next_cycle();

        chk("wb_count", n_wb, 10);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
